rw_port_sched: RTL and testbench

- Schedules a single-port storage resource shared between a read requester and a write requester.
- Drives registered, mutually exclusive `read`/`write` strobes to the resource, plus delayed completion flags (`ready` for writes, `rd_valid` for reads).
- Inserts bus-turnaround idle cycles on every direction change.
- Bounds burst length so neither requester starves.
- Sits between the requester logic and the storage; its outputs feed the existing `!(read && write)` and `write |-> ready` properties directly.

---
 rtl/rw_port_sched.sv | 201 ++++++++++++++++++++
 tb/tb_rw_port_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_port_sched.sv
// rw_port_sched
//   Shares one single-port storage resource between a read requester and a
//   write requester. It issues registered, mutually exclusive read/write
//   strobes and inserts bus-turnaround idle cycles on every direction change.
//   It also caps burst length so that a waiting requester is served within
//   MAX_BURST + TURNAROUND + 1 cycles.
//
// Parameters
//   MAX_BURST  : consecutive strobes allowed in one direction while the other
//                requester waits (1..15)
//   TURNAROUND : minimum idle cycles between opposite-direction strobes (0..3)
//
// Ports
//   clock    in   single clock, posedge
//   resetn   in   synchronous active-low reset
//   rd_req   in   level read request; one read consumed per granted cycle
//   wr_req   in   level write request; one write consumed per granted cycle
//   read     out  registered read strobe to the resource
//   write    out  registered write strobe to the resource
//   ready    out  write acknowledge, write delayed one cycle
//   rd_valid out  read data valid, read delayed one cycle
//   busy     out  high during turnaround cycles
module rw_port_sched #(
    parameter int MAX_BURST  = 4,
    parameter int TURNAROUND = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic rd_req,
    input  logic wr_req,
    output logic read,
    output logic write,
    output logic ready,
    output logic rd_valid,
    output logic busy
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);
    localparam logic [1:0] TA   = 2'(TURNAROUND);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;
    typedef enum logic {DIR_RD, DIR_WR} dir_t;

    state_t     state;
    dir_t       last_dir;
    dir_t       target;
    logic [3:0] burst_cnt;
    logic [1:0] gap_cnt;

    dir_t idle_tgt;
    logic gap_ok;
    logic tgt_req;

    function automatic logic [3:0] burst_inc(input logic [3:0] b);
        return (b == 4'hF) ? b : b + 4'd1;
    endfunction

    function automatic logic [1:0] gap_inc(input logic [1:0] g);
        return (g >= TA) ? g : g + 2'd1;
    endfunction

    // On a tie, serve the direction that was not served last.
    assign idle_tgt = (rd_req && wr_req) ? ((last_dir == DIR_WR) ? DIR_RD : DIR_WR)
                                         : (wr_req ? DIR_WR : DIR_RD);
    assign gap_ok   = (gap_cnt >= TA);
    assign tgt_req  = (target == DIR_WR) ? wr_req : rd_req;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= S_IDLE;
            read      <= 1'b0;
            write     <= 1'b0;
            ready     <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            gap_cnt   <= TA;        // no turnaround owed after reset
            last_dir  <= DIR_WR;    // first tie goes to read
            target    <= DIR_RD;
        end else begin
            ready    <= write;
            rd_valid <= read;
            read     <= 1'b0;
            write    <= 1'b0;
            busy     <= 1'b0;
            gap_cnt  <= gap_inc(gap_cnt);

            case (state)
                S_IDLE: begin
                    burst_cnt <= '0;
                    if (rd_req || wr_req) begin
                        if (idle_tgt == last_dir || gap_ok) begin
                            last_dir <= idle_tgt;
                            gap_cnt  <= '0;
                            if (idle_tgt == DIR_RD) begin
                                state     <= S_RD;
                                read      <= 1'b1;
                                burst_cnt <= wr_req ? 4'd1 : 4'd0;
                            end else begin
                                state     <= S_WR;
                                write     <= 1'b1;
                                burst_cnt <= rd_req ? 4'd1 : 4'd0;
                            end
                        end else begin
                            state  <= S_TURN;
                            busy   <= 1'b1;
                            target <= idle_tgt;
                        end
                    end
                end

                S_RD: begin
                    if (!rd_req) begin
                        state     <= S_IDLE;
                        burst_cnt <= '0;
                    end else if (wr_req && burst_cnt >= MAXB) begin
                        if (TURNAROUND == 0) begin
                            state     <= S_WR;
                            write     <= 1'b1;
                            last_dir  <= DIR_WR;
                            gap_cnt   <= '0;
                            burst_cnt <= 4'd1;  // reader is still waiting
                        end else begin
                            state     <= S_TURN;
                            busy      <= 1'b1;
                            target    <= DIR_WR;
                            burst_cnt <= '0;
                        end
                    end else begin
                        read    <= 1'b1;
                        gap_cnt <= '0;
                        if (wr_req)
                            burst_cnt <= burst_inc(burst_cnt);
                    end
                end

                S_WR: begin
                    if (!wr_req) begin
                        state     <= S_IDLE;
                        burst_cnt <= '0;
                    end else if (rd_req && burst_cnt >= MAXB) begin
                        if (TURNAROUND == 0) begin
                            state     <= S_RD;
                            read      <= 1'b1;
                            last_dir  <= DIR_RD;
                            gap_cnt   <= '0;
                            burst_cnt <= 4'd1;  // writer is still waiting
                        end else begin
                            state     <= S_TURN;
                            busy      <= 1'b1;
                            target    <= DIR_RD;
                            burst_cnt <= '0;
                        end
                    end else begin
                        write   <= 1'b1;
                        gap_cnt <= '0;
                        if (rd_req)
                            burst_cnt <= burst_inc(burst_cnt);
                    end
                end

                S_TURN: begin
                    burst_cnt <= '0;
                    if (tgt_req && gap_ok) begin
                        last_dir <= target;
                        gap_cnt  <= '0;
                        if (target == DIR_WR) begin
                            state     <= S_WR;
                            write     <= 1'b1;
                            burst_cnt <= rd_req ? 4'd1 : 4'd0;
                        end else begin
                            state     <= S_RD;
                            read      <= 1'b1;
                            burst_cnt <= wr_req ? 4'd1 : 4'd0;
                        end
                    end else if (tgt_req) begin
                        busy <= 1'b1;
                    end else if (rd_req || wr_req) begin
                        // The remaining request is the direction just served,
                        // so the bus needs no turnaround to go back to it.
                        gap_cnt <= '0;
                        if (target == DIR_WR) begin
                            state    <= S_RD;
                            read     <= 1'b1;
                            last_dir <= DIR_RD;
                        end else begin
                            state    <= S_WR;
                            write    <= 1'b1;
                            last_dir <= DIR_WR;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rw_port_sched.sv
module tb_rw_port_sched;

    localparam int MB = 4;
    localparam int TA = 1;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic rd_req = 1'b0, wr_req = 1'b0;
    logic rd2 = 1'b0, wr2 = 1'b0;
    logic read, write, ready, rd_valid, busy;
    logic read2, write2, ready2, rd_valid2, busy2;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    always #5 clock = ~clock;

    rw_port_sched #(.MAX_BURST(MB), .TURNAROUND(TA)) dut (
        .clock(clock), .resetn(resetn), .rd_req(rd_req), .wr_req(wr_req),
        .read(read), .write(write), .ready(ready), .rd_valid(rd_valid), .busy(busy)
    );

    rw_port_sched #(.MAX_BURST(1), .TURNAROUND(0)) dut2 (
        .clock(clock), .resetn(resetn), .rd_req(rd2), .wr_req(wr2),
        .read(read2), .write(write2), .ready(ready2), .rd_valid(rd_valid2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Outputs are {read, write, ready, rd_valid, busy}.
    task automatic test_reset();
        logic [4:0] got;
        resetn = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; rd2 = 1'b1; wr2 = 1'b1;
        tick();
        tick();
        got = {read, write, ready, rd_valid, busy};
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("FAIL reset_dut got %b exp 00000", got);
        end
        got = {read2, write2, ready2, rd_valid2, busy2};
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("FAIL reset_dut2 got %b exp 00000", got);
        end
        do_reset();
    endtask

    // Table entries are {resetn, rd_req, wr_req, expected outputs after the edge}.
    task automatic test_read_burst();
        logic [7:0] tbl [5] = '{8'b1_10_10000, 8'b1_10_10010, 8'b1_10_10010,
                                8'b1_00_00010, 8'b1_00_00000};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            resetn = tbl[i][7]; rd_req = tbl[i][6]; wr_req = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read, write, ready, rd_valid, busy};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_burst cyc %0d got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_both_default();
        logic [7:0] tbl [14] = '{8'b1_11_10000, 8'b1_11_10010, 8'b1_11_10010, 8'b1_11_10010,
                                 8'b1_11_00011, 8'b1_11_01000, 8'b1_11_01100, 8'b1_11_01100,
                                 8'b1_11_01100, 8'b1_11_00101, 8'b1_11_10000, 8'b1_11_10010,
                                 8'b1_00_00010, 8'b1_00_00000};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            resetn = tbl[i][7]; rd_req = tbl[i][6]; wr_req = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read, write, ready, rd_valid, busy};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL both_default cyc %0d got %b exp %b", i, got, exp);
            end
        end
    endtask

    // Writer gives up during the turnaround: go back to reading at once.
    task automatic test_turn_abort();
        logic [7:0] tbl [7] = '{8'b1_11_10000, 8'b1_11_10010, 8'b1_11_10010, 8'b1_11_10010,
                                8'b1_11_00011, 8'b1_10_10000, 8'b1_00_00010};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            resetn = tbl[i][7]; rd_req = tbl[i][6]; wr_req = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read, write, ready, rd_valid, busy};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL turn_abort cyc %0d got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_write_idle_read();
        logic [7:0] tbl [7] = '{8'b1_01_01000, 8'b1_00_00100, 8'b1_00_00000, 8'b1_00_00000,
                                8'b1_10_10000, 8'b1_00_00010, 8'b1_00_00000};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            resetn = tbl[i][7]; rd_req = tbl[i][6]; wr_req = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read, write, ready, rd_valid, busy};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL write_idle_read cyc %0d got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tbl [4] = '{8'b1_01_01000, 8'b0_01_00000, 8'b1_10_10000, 8'b1_00_00010};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            resetn = tbl[i][7]; rd_req = tbl[i][6]; wr_req = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read, write, ready, rd_valid, busy};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %b exp %b", i, got, exp);
            end
        end
    endtask

    // Second instance: TURNAROUND=0, MAX_BURST=1.
    task automatic test_alternate();
        logic [6:0] tbl [8] = '{7'b11_10000, 7'b11_01010, 7'b11_10100, 7'b11_01010,
                                7'b11_10100, 7'b11_01010, 7'b00_00100, 7'b00_00000};
        logic [4:0] got, exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd2 = tbl[i][6]; wr2 = tbl[i][5];
            exp_q.push_back(tbl[i][4:0]);
            tick();
            got = {read2, write2, ready2, rd_valid2, busy2};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL alternate cyc %0d got %b exp %b", i, got, exp);
            end
        end
        rd2 = 1'b0; wr2 = 1'b0;
    endtask

    task automatic test_random();
        logic prev_read, prev_write, rd_at_edge, wr_at_edge;
        int rwait = 0, wwait = 0;
        int n_rd = 0, n_wr = 0, n_turn = 0;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) rd_req = ~rd_req;
            if ($urandom_range(0, 5) == 0) wr_req = ~wr_req;
            prev_read  = read;
            prev_write = write;
            rd_at_edge = rd_req;
            wr_at_edge = wr_req;
            tick();
            if (read)  n_rd++;
            if (write) n_wr++;
            if (busy)  n_turn++;
            checks++;
            if (read && write) begin
                errors++;
                $display("FAIL rand_excl cyc %0d got read=%b write=%b exp not both", i, read, write);
            end
            checks++;
            if (ready !== prev_write) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b exp %b", i, ready, prev_write);
            end
            checks++;
            if (rd_valid !== prev_read) begin
                errors++;
                $display("FAIL rand_rd_valid cyc %0d got %b exp %b", i, rd_valid, prev_read);
            end
            checks++;
            if (busy && (read || write)) begin
                errors++;
                $display("FAIL rand_busy_strobe cyc %0d got busy=1 read=%b write=%b exp no strobe", i, read, write);
            end
            rwait = !rd_at_edge ? 0 : (read  ? 0 : rwait + 1);
            wwait = !wr_at_edge ? 0 : (write ? 0 : wwait + 1);
            checks++;
            if (rwait > MB + TA + 1 || wwait > MB + TA + 1) begin
                errors++;
                $display("FAIL rand_starve cyc %0d got rwait=%0d wwait=%0d exp <= %0d", i, rwait, wwait, MB + TA + 1);
            end
        end
        checks++;
        if (n_rd == 0 || n_wr == 0 || n_turn == 0) begin
            errors++;
            $display("FAIL rand_activity got rd=%0d wr=%0d turn=%0d exp all nonzero", n_rd, n_wr, n_turn);
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_both_default();
        test_turn_abort();
        test_write_idle_read();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
